detect_drain: RTL

- Consumes one frame of per-lane detect records, i.e. a packed array of {index, match} entries as produced by the per-character detect stage.
- Serialises only the matching entries onto a single ready/valid output stream, lowest lane first, with a last flag on the final match of each frame.
- Sits between the parallel detect lanes and the downstream single-entry consumer; counts frames that contain no match.

---
 rtl/detect_drain.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/detect_drain.sv
// detect_drain
//
// Takes one frame of per-lane detect records and serialises only the matching
// entries onto a single ready/valid stream, lowest lane first. The final match
// of each frame carries out_last. Frames with no match at all are counted, not
// emitted.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   det_valid  frame on det_in is valid
//   det_ready  block is idle and can take a frame
//   det_in     NUM_CHARS packed entries; entry g = det_in[g*(IDX_W+1) +: IDX_W+1],
//              {index[IDX_W-1:0], match}
//   out_valid  out_* holds a match waiting for transfer
//   out_ready  downstream accepts the presented match
//   out_index  index field of the presented entry
//   out_lane   lane number of the presented entry
//   out_last   presented entry is the final match of its frame
//   empty_cnt  saturating count of accepted frames with no match

module detect_drain #(
    parameter int unsigned NUM_CHARS = 4,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             det_valid,
    output logic                             det_ready,
    input  logic [NUM_CHARS*(IDX_W+1)-1:0]   det_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [IDX_W-1:0]                 out_index,
    output logic [$clog2(NUM_CHARS)-1:0]     out_lane,
    output logic                             out_last,
    output logic [CNT_W-1:0]                 empty_cnt
);

    localparam int unsigned LANE_W  = $clog2(NUM_CHARS);
    localparam int unsigned ENTRY_W = IDX_W + 1;

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e                          state_q, state_d;
    logic [NUM_CHARS-1:0]            pending_q, pending_d;
    logic [NUM_CHARS-1:0][IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]                empty_cnt_q, empty_cnt_d;

    logic                            out_valid_q, out_valid_d;
    logic [IDX_W-1:0]                out_index_q, out_index_d;
    logic [LANE_W-1:0]               out_lane_q, out_lane_d;
    logic                            out_last_q, out_last_d;

    logic [LANE_W-1:0]               low_lane;
    logic                            one_left;

    // Next-state: frame capture, pending-mask drain and empty-frame counting.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        idx_d       = idx_q;
        empty_cnt_d = empty_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (det_valid) begin
                    for (int g = 0; g < NUM_CHARS; g++) begin
                        idx_d[g]     = det_in[g*ENTRY_W + 1 +: IDX_W];
                        pending_d[g] = det_in[g*ENTRY_W];
                    end
                    if (pending_d != '0) begin
                        state_d = StDrain;
                    end else if (empty_cnt_q != {CNT_W{1'b1}}) begin
                        empty_cnt_d = empty_cnt_q + CNT_W'(1);
                    end
                end
            end
            StDrain: begin
                // out_valid is always set in this state, so out_ready alone
                // completes a transfer of the presented lane.
                if (out_ready) begin
                    pending_d[out_lane_q] = 1'b0;
                    if (pending_d == '0) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output registers are loaded from the next pending mask so a match shows
    // up the cycle after capture and stays put while the mask is unchanged.
    always_comb begin
        low_lane = '0;
        for (int g = NUM_CHARS - 1; g >= 0; g--) begin
            if (pending_d[g]) begin
                low_lane = LANE_W'(g);
            end
        end

        // Clearing the lowest set bit leaves zero iff exactly one bit was set.
        one_left = (pending_d != '0) &&
                   ((pending_d & (pending_d - NUM_CHARS'(1))) == '0);

        out_valid_d = (pending_d != '0);
        out_lane_d  = '0;
        out_index_d = '0;
        out_last_d  = 1'b0;
        if (out_valid_d) begin
            out_lane_d  = low_lane;
            out_index_d = idx_d[low_lane];
            out_last_d  = one_left;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            pending_q   <= '0;
            idx_q       <= '0;
            empty_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_lane_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            idx_q       <= idx_d;
            empty_cnt_q <= empty_cnt_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_lane_q  <= out_lane_d;
            out_last_q  <= out_last_d;
        end
    end

    assign det_ready = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_lane  = out_lane_q;
    assign out_last  = out_last_q;
    assign empty_cnt = empty_cnt_q;

endmodule
